// File: rtl/pdp_pkg.sv
// Shared types, defaults and helpers for the path delay probe.
// FSM states are plain localparam codes so legacy tools without enum support can still read them.
package pdp_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_PRESET  = 3'd1;
  localparam state_t ST_LAUNCH  = 3'd2;
  localparam state_t ST_CAPTURE = 3'd3;
  localparam state_t ST_CHECK   = 3'd4;
  localparam state_t ST_DONE    = 3'd5;

  localparam int TRIALS_DEF    = 256;
  localparam int CNT_W_DEF     = 9;
  localparam int SETTLE_DEF    = 8;
  localparam int INVERTING_DEF = 0;

  // Increment that sticks at max_value instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
    return (value >= max_value) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/path_delay_probe_if.sv
// Run-control handshake between a host and path_delay_probe.
// PATH_DELAY_PROBE_FIRST_FAIL_EN adds the first-failing-trial report signals.
interface path_delay_probe_if #(parameter int CNT_W = 9) ();

  logic             start;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] fail_count;

`ifdef PATH_DELAY_PROBE_FIRST_FAIL_EN
  logic [CNT_W-1:0] first_fail;
  logic             first_fail_vld;

  modport master (output start, input busy, input done, input fail_count,
                  input first_fail, input first_fail_vld);
  modport slave  (input start, output busy, output done, output fail_count,
                  output first_fail, output first_fail_vld);
`else
  modport master (output start, input busy, input done, input fail_count);
  modport slave  (input start, output busy, output done, output fail_count);
`endif

endinterface

// File: rtl/pdp_launch_capture.sv
// Launch and capture flops bracketing the delay chain under test.
// Both are kept so synthesis cannot merge or retime across the measured arc.
module pdp_launch_capture (
  input  logic clk,
  input  logic rst,
  input  logic launch_d,
  input  logic cap_en,
  input  logic path_out,
  output logic path_in,
  output logic cap_q
);

  (* keep = 1 *) logic launch_q;
  (* keep = 1 *) logic capture_q;

  // path_out is sampled raw: a metastable or late value is exactly what is being measured.
  always_ff @(posedge clk) begin
    if (rst) begin
      launch_q  <= 1'b0;
      capture_q <= 1'b0;
    end else begin
      launch_q <= launch_d;
      if (cap_en) capture_q <= path_out;
    end
  end

  assign path_in = launch_q;
  assign cap_q   = capture_q;

endmodule

// File: rtl/path_delay_probe.sv
// Launch/capture controller: runs TRIALS single-cycle timing trials on a delay chain and counts failures.
// Optional: define PATH_DELAY_PROBE_FIRST_FAIL_EN to report the index of the first failing trial.
module path_delay_probe
  import pdp_pkg::*;
#(
  parameter int TRIALS    = TRIALS_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int SETTLE    = SETTLE_DEF,
  parameter int INVERTING = INVERTING_DEF
) (
  input  logic                clk,
  input  logic                rst,
  path_delay_probe_if.slave   bus,
  output logic                path_in,
  input  logic                path_out
);

  localparam int SET_W = $clog2(SETTLE + 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] TRIAL_LAST  = CNT_W'(TRIALS - 1);
  localparam logic [31:0]      CNT_MAX     = 32'({CNT_W{1'b1}});
  localparam logic             INV         = (INVERTING != 0);

  state_t           state;
  logic [CNT_W-1:0] trial;
  logic [CNT_W-1:0] fail_count;
  logic [SET_W-1:0] settle_cnt;
  logic             launch_val;
  logic             launch_d;
  logic             cap_en;
  logic             cap_q;
  logic             is_fail;

  // Even trials launch a rising edge, odd trials a falling edge.
  assign launch_val = ~trial[0];
  assign is_fail    = (cap_q != (launch_val ^ INV));
  assign cap_en     = (state == ST_CAPTURE);

  always_comb begin
    launch_d = path_in;
    case (state)
      ST_IDLE:                          launch_d = 1'b0;
      ST_PRESET:                        launch_d = ~launch_val;
      ST_LAUNCH, ST_CAPTURE, ST_CHECK:  launch_d = launch_val;
      default:                          launch_d = path_in;
    endcase
  end

  pdp_launch_capture u_lc (
    .clk      (clk),
    .rst      (rst),
    .launch_d (launch_d),
    .cap_en   (cap_en),
    .path_out (path_out),
    .path_in  (path_in),
    .cap_q    (cap_q)
  );

`ifdef PATH_DELAY_PROBE_FIRST_FAIL_EN
  logic [CNT_W-1:0] first_fail;
  logic             first_fail_vld;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      trial      <= '0;
      settle_cnt <= '0;
      fail_count <= '0;
`ifdef PATH_DELAY_PROBE_FIRST_FAIL_EN
      first_fail     <= '0;
      first_fail_vld <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state      <= ST_PRESET;
            trial      <= '0;
            settle_cnt <= '0;
            fail_count <= '0;
`ifdef PATH_DELAY_PROBE_FIRST_FAIL_EN
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
`endif
          end
        end
        ST_PRESET: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= ST_LAUNCH;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ST_LAUNCH:  state <= ST_CAPTURE;
        ST_CAPTURE: state <= ST_CHECK;
        ST_CHECK: begin
          if (is_fail) begin
            fail_count <= CNT_W'(sat_inc(32'(fail_count), CNT_MAX));
`ifdef PATH_DELAY_PROBE_FIRST_FAIL_EN
            if (!first_fail_vld) begin
              first_fail     <= trial;
              first_fail_vld <= 1'b1;
            end
`endif
          end
          if (trial == TRIAL_LAST) begin
            state <= ST_DONE;
          end else begin
            trial <= trial + 1'b1;
            state <= ST_PRESET;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy       = (state != ST_IDLE) && (state != ST_DONE);
  assign bus.done       = (state == ST_DONE);
  assign bus.fail_count = fail_count;

`ifdef PATH_DELAY_PROBE_FIRST_FAIL_EN
  assign bus.first_fail     = first_fail;
  assign bus.first_fail_vld = first_fail_vld;
`else
`endif

endmodule
